mem_bus_arbiter: RTL and testbench

Sequences the single shared 16-bit memory bus (readM/writeM/address/data with inputReady/ackOutput handshake) between two requesters: an instruction-fetch port and a data (load/store) port. It owns all bus strobes and the tri-state data driver, runs the full request/acknowledge/release handshake, enforces a bounded starvation limit for fetch, and aborts hung transactions with a timeout. Sits between the CPU core and the memory model.

---
 rtl/mem_bus_arbiter_pkg.sv | 19 +
 rtl/mem_bus_timeout.sv | 31 +++
 rtl/mem_bus_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the two-port memory bus arbiter: bus width,
// sequencer state encodings and transaction owner encoding.
package mem_bus_arbiter_pkg;

    localparam int MB_WORD_SIZE = 16;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_READ    = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    function automatic logic is_xfer(input logic [1:0] st);
        return (st == ST_READ) || (st == ST_WRITE);
    endfunction

endpackage

// File: rtl/mem_bus_timeout.sv
// Cycle counter that flags a hung bus transaction; TIMEOUT_CYCLES = 0
// disables expiry entirely.
module mem_bus_timeout #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Fires on the edge that would complete the TIMEOUT_CYCLES-th strobe cycle.
    assign expired = (TIMEOUT_CYCLES != 0) && enable && (cnt == CW'(LAST));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single shared memory bus between the fetch port and the
// data port, owning the strobes, the tri-state data driver and the timeout.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int WORD_SIZE      = MB_WORD_SIZE,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 if_req,
    input  logic [WORD_SIZE-1:0] if_addr,
    output logic [WORD_SIZE-1:0] if_rdata,
    output logic                 if_done,
    input  logic                 dm_req,
    input  logic                 dm_we,
    input  logic [WORD_SIZE-1:0] dm_addr,
    input  logic [WORD_SIZE-1:0] dm_wdata,
    output logic [WORD_SIZE-1:0] dm_rdata,
    output logic                 dm_done,
    output logic                 err,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    input  logic                 inputReady,
    input  logic                 ackOutput,
    output logic [1:0]           dbg_state
);

    // Requester handshake: req is held until the matching done pulse; done is
    // a single cycle, rdata is valid with it, and err accompanies it on timeout.
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [1:0]           state;
    logic                 owner;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [SW-1:0]        starve_cnt;
    logic                 grant_if;
    logic                 expired;

    assign grant_if  = if_req && (!dm_req || (starve_cnt == SW'(STARVE_LIMIT)));
    assign data      = writeM ? wdata_q : {WORD_SIZE{1'bz}};
    assign dbg_state = state;

    mem_bus_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (reset_n),
        .clear  (state == ST_IDLE),
        .enable (is_xfer(state)),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state      <= ST_IDLE;
            owner      <= OWN_IF;
            wdata_q    <= '0;
            starve_cnt <= '0;
            address    <= '0;
            readM      <= 1'b0;
            writeM     <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_done    <= 1'b0;
            dm_done    <= 1'b0;
            err        <= 1'b0;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
            err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!if_req) starve_cnt <= '0;
                    if (grant_if) begin
                        address    <= if_addr;
                        owner      <= OWN_IF;
                        starve_cnt <= '0;
                        readM      <= 1'b1;
                        state      <= ST_READ;
                    end else if (dm_req) begin
                        address <= dm_addr;
                        owner   <= OWN_DM;
                        wdata_q <= dm_wdata;
                        // Losing fetch accumulates credit until it is forced through.
                        if (if_req) starve_cnt <= starve_cnt + SW'(1);
                        if (dm_we) begin
                            writeM <= 1'b1;
                            state  <= ST_WRITE;
                        end else begin
                            readM <= 1'b1;
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (inputReady || expired) begin
                        readM <= 1'b0;
                        err   <= !inputReady;
                        state <= ST_RELEASE;
                        if (owner == OWN_IF) begin
                            if_rdata <= inputReady ? data : {WORD_SIZE{1'b1}};
                            if_done  <= 1'b1;
                        end else begin
                            dm_rdata <= inputReady ? data : {WORD_SIZE{1'b1}};
                            dm_done  <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (ackOutput || expired) begin
                        writeM  <= 1'b0;
                        err     <= !ackOutput;
                        dm_done <= 1'b1;
                        state   <= ST_RELEASE;
                    end
                end
                default: begin
                    // Previous acknowledge must be gone before any new strobe.
                    if (!inputReady && !ackOutput) state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: requester drivers, a behavioural memory,
// and a monitor that checks completions and grants against expected queues.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         if_req, dm_req, dm_we;
    logic [W-1:0] if_addr, dm_addr, dm_wdata;
    logic [W-1:0] if_rdata, dm_rdata, address;
    logic         if_done, dm_done, err, readM, writeM;
    logic         inputReady, ackOutput;
    logic [1:0]   dbg_state;
    wire  [W-1:0] data;

    logic         mem_oe, probe_oe;
    logic [W-1:0] mem_q, probe_val;
    assign data = mem_oe ? mem_q : (probe_oe ? probe_val : {W{1'bz}});

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .WORD_SIZE(W), .STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done), .err(err),
        .readM(readM), .writeM(writeM), .address(address), .data(data),
        .inputReady(inputReady), .ackOutput(ackOutput), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [W+1:0] exp_if_q[$];   // {check_rdata, err, rdata}
    logic [W+1:0] exp_dm_q[$];
    logic [W-1:0] exp_grant_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int last_strobe_len = 0;
    int last_gap = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- memory model ----------------
    int           lat   = 1;
    int           hold  = 0;
    bit           noack = 1'b0;
    logic [W-1:0] mem[logic [W-1:0]];
    logic [W-1:0] last_wdata = '0;

    initial begin
        int cnt;
        int hcnt;
        cnt = 0;
        hcnt = 0;
        inputReady = 1'b0;
        ackOutput  = 1'b0;
        mem_oe     = 1'b0;
        mem_q      = '0;
        forever begin
            @(negedge clk);
            if (inputReady || ackOutput) begin
                if (!readM && !writeM) begin
                    hcnt++;
                    if (hcnt > hold) begin
                        inputReady = 1'b0;
                        ackOutput  = 1'b0;
                        mem_oe     = 1'b0;
                        hcnt = 0;
                        cnt  = 0;
                    end
                end
            end else if ((readM || writeM) && !noack) begin
                cnt++;
                if (cnt >= lat) begin
                    if (readM) begin
                        mem_q      = mem.exists(address) ? mem[address] : '0;
                        mem_oe     = 1'b1;
                        inputReady = 1'b1;
                    end else begin
                        mem[address] = data;
                        last_wdata   = data;
                        ackOutput    = 1'b1;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [W+1:0] e;
        bit prev_strobe;
        bit prev_ack;
        bit strobe;
        bit ack;
        int idx;
        int ack_fall_idx;
        int slen;
        prev_strobe = 1'b0; prev_ack = 1'b0;
        idx = 0; ack_fall_idx = 0; slen = 0;
        forever begin
            @(posedge clk);
            #1;
            idx++;
            if (if_done) begin
                if (exp_if_q.size() == 0) fail_now("if_done_unexpected");
                else begin
                    e = exp_if_q.pop_front();
                    if (e[W+1]) check("if_rdata", if_rdata, e[W-1:0]);
                    check("if_err", err, e[W]);
                end
            end
            if (dm_done) begin
                if (exp_dm_q.size() == 0) fail_now("dm_done_unexpected");
                else begin
                    e = exp_dm_q.pop_front();
                    if (e[W+1]) check("dm_rdata", dm_rdata, e[W-1:0]);
                    check("dm_err", err, e[W]);
                end
            end
            if (err && !if_done && !dm_done) fail_now("err_without_done");
            if (readM && writeM) fail_now("both_strobes");
            strobe = readM || writeM;
            ack    = inputReady || ackOutput;
            if (prev_ack && !ack) ack_fall_idx = idx;
            if (strobe && !prev_strobe) begin
                check("ack_low_at_strobe", ack, 0);
                if (exp_grant_q.size() == 0) fail_now("grant_unexpected");
                else check("grant_addr", address, exp_grant_q.pop_front());
                last_gap = idx - ack_fall_idx;
                slen = 0;
            end
            if (strobe) slen++;
            if (!strobe && prev_strobe) last_strobe_len = slen;
            prev_strobe = strobe;
            prev_ack    = ack;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fetch(input logic [W-1:0] a, input logic [W-1:0] exp, input bit keep);
        bit seen;
        seen = 1'b0;
        exp_if_q.push_back({1'b1, 1'b0, exp});
        if_addr = a;
        if_req  = 1'b1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = if_done;
        end
        if (!seen) fail_now("if_done_timeout");
        if (!keep || !seen) if_req = 1'b0;
    endtask

    task automatic dm_op(input bit we, input logic [W-1:0] a, input logic [W-1:0] wd,
                         input logic [W-1:0] exp, input bit exp_err, input bit keep);
        bit seen;
        seen = 1'b0;
        exp_dm_q.push_back({!we, exp_err, exp});
        dm_we    = we;
        dm_addr  = a;
        dm_wdata = wd;
        dm_req   = 1'b1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = dm_done;
        end
        if (!seen) fail_now("dm_done_timeout");
        if (!keep || !seen) dm_req = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit seen;
        reset_n = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        probe_oe = 1'b0; probe_val = '0;
        mem[16'h0010] = 16'h6A05;
        mem[16'h0100] = 16'hC0DE;
        mem[16'h0104] = 16'hF00D;
        for (int i = 0; i < 8; i++) mem[16'h0200 + 16'(i)] = 16'h1000 + 16'(i);
        mem[16'h0300] = 16'h1111;
        mem[16'h0310] = 16'h2222;
        mem[16'h0410] = 16'h7777;

        idle(3);
        check("rst_readM", readM, 0);
        check("rst_writeM", writeM, 0);
        check("rst_address", address, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        check("rst_dones", {if_done, dm_done, err}, 0);
        check("rst_state", dbg_state, 0);
        reset_n = 1'b0;
        idle(2);

        // Fetch with a two-cycle memory
        lat = 2;
        exp_grant_q.push_back(16'h0010);
        fetch(16'h0010, 16'h6A05, 1'b0);
        idle(3);
        check("fetch_strobe_len", last_strobe_len, 2);

        // Store, then bus released, then read back at minimum latency
        lat = 1;
        exp_grant_q.push_back(16'h0040);
        dm_op(1'b1, 16'h0040, 16'hBEEF, 16'h0000, 1'b0, 1'b0);
        idle(3);
        check("store_data_on_bus", last_wdata, 16'hBEEF);
        probe_oe = 1'b1; probe_val = 16'h5A5A;
        #1;
        check("data_released_after_write", data, 16'h5A5A);
        probe_oe = 1'b0;
        exp_grant_q.push_back(16'h0040);
        dm_op(1'b0, 16'h0040, 16'h0000, 16'hBEEF, 1'b0, 1'b0);
        idle(3);
        check("min_read_strobe_len", last_strobe_len, 1);

        // Contention: D,D,D,D,F,D,D,D,D,F
        for (int i = 0; i < 4; i++) exp_grant_q.push_back(16'h0200 + 16'(i));
        exp_grant_q.push_back(16'h0100);
        for (int i = 4; i < 8; i++) exp_grant_q.push_back(16'h0200 + 16'(i));
        exp_grant_q.push_back(16'h0104);
        fork
            begin
                fetch(16'h0100, 16'hC0DE, 1'b1);
                fetch(16'h0104, 16'hF00D, 1'b0);
            end
            begin
                for (int i = 0; i < 8; i++)
                    dm_op(1'b0, 16'h0200 + 16'(i), 16'h0000, 16'h1000 + 16'(i), 1'b0, i < 7);
            end
        join
        idle(3);
        check("contention_grants_consumed", exp_grant_q.size(), 0);

        // Timeout on a load that is never acknowledged
        noack = 1'b1;
        exp_grant_q.push_back(16'h0080);
        dm_op(1'b0, 16'h0080, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
        idle(3);
        check("timeout_strobe_len", last_strobe_len, 8);
        check("timeout_dm_rdata", dm_rdata, 16'hFFFF);
        noack = 1'b0;

        // Slow release: acknowledge lingers five cycles, pending fetch waits
        hold = 5;
        exp_grant_q.push_back(16'h0300);
        exp_grant_q.push_back(16'h0310);
        fork
            dm_op(1'b0, 16'h0300, 16'h0000, 16'h1111, 1'b0, 1'b0);
            fetch(16'h0310, 16'h2222, 1'b0);
        join
        idle(3);
        check("slow_release_gap", last_gap, 1);
        hold = 0;

        // Reset in the middle of a read
        noack = 1'b1;
        exp_grant_q.push_back(16'h0400);
        if_addr = 16'h0400;
        if_req  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = readM;
        end
        if (!seen) fail_now("reset_test_no_strobe");
        idle(1);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        #1;
        check("reset_mid_readM", readM, 0);
        check("reset_mid_state", dbg_state, 0);
        check("reset_mid_if_rdata", if_rdata, 0);
        probe_oe = 1'b1; probe_val = 16'hA5A5;
        #1;
        check("reset_mid_data_hiz", data, 16'hA5A5);
        probe_oe = 1'b0;
        if_req = 1'b0;
        noack  = 1'b0;
        idle(2);
        reset_n = 1'b0;
        idle(2);
        exp_grant_q.push_back(16'h0410);
        fetch(16'h0410, 16'h7777, 1'b0);
        idle(4);

        check("if_queue_drained", exp_if_q.size(), 0);
        check("dm_queue_drained", exp_dm_q.size(), 0);
        check("grant_queue_drained", exp_grant_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
